// File: rtl/team_06_audio_path.sv
// rtl/team_06_audio_path.sv - talk/listen audio datapath: voice effects, tremolo LFO, speaker volume
// Optional delay line for ECHO/REVERB is built when TEAM_06_DELAY_LINE_EN is defined.
module team_06_audio_path #(
    parameter int DEPTH    = 16,
    parameter int TREM_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [7:0] mic_aud,
    input  logic [7:0] spk_aud,
    input  logic       state,
    input  logic       eff_en,
    input  logic       vol_en,
    input  logic [2:0] current_effect,
    input  logic       mute_tog,
    input  logic [2:0] vol,
    output logic [7:0] tx_aud,
    output logic       tx_valid,
    output logic [7:0] spk_out,
    output logic       spk_valid
);
    localparam int DW = (TREM_DIV > 1) ? $clog2(TREM_DIV) : 1;
    localparam logic [2:0] EFF_ECHO   = 3'b001;
    localparam logic [2:0] EFF_TREM   = 3'b010;
    localparam logic [2:0] EFF_REVERB = 3'b011;
    localparam logic [2:0] EFF_SOFT   = 3'b100;

    typedef enum logic [1:0] {P_IDLE, P_COMP, P_OUT} pipe_t;
    pipe_t pipe_q, pipe_d;

    logic signed [8:0] x_mic_q, x_mic_d, x_spk_q, x_spk_d;
    logic       talk_q, talk_d, eff_en_q, eff_en_d, vol_en_q, vol_en_d, mute_q, mute_d;
    logic [2:0] effect_q, effect_d, prev_effect_q, prev_effect_d, vol_q, vol_d;
    logic [7:0] tx_aud_q, tx_aud_d, spk_out_q, spk_out_d;
    logic       tx_valid_q, tx_valid_d, spk_valid_q, spk_valid_d;
    logic [3:0] gain_q, gain_d;
    logic       gain_up_q, gain_up_d;
    logic [DW-1:0] div_q, div_d;

    logic              changed, dir_cur;
    logic [3:0]        g_cur;
    logic [DW-1:0]     div_cur;
    logic signed [15:0] xm, xs, y, prod, vm, sp;
    logic [7:0]        c;

`ifdef TEAM_06_DELAY_LINE_EN
    localparam int PW = $clog2(DEPTH);
    logic [7:0]        line_q [DEPTH];
    logic [7:0]        line_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, ptr_cur;
    logic [7:0]        wr_val;
    logic signed [15:0] d16;
`endif

    // Saturate a centred value to the signed 8-bit range.
    function automatic logic [7:0] clamp8(input logic signed [15:0] v);
        if (v > 16'sd127)       return 8'h7f;
        else if (v < -16'sd128) return 8'h80;
        else                    return v[7:0];
    endfunction

    always_comb begin
        pipe_d        = pipe_q;
        x_mic_d       = x_mic_q;
        x_spk_d       = x_spk_q;
        talk_d        = talk_q;
        eff_en_d      = eff_en_q;
        vol_en_d      = vol_en_q;
        mute_d        = mute_q;
        effect_d      = effect_q;
        vol_d         = vol_q;
        prev_effect_d = prev_effect_q;
        tx_aud_d      = tx_aud_q;
        spk_out_d     = spk_out_q;
        tx_valid_d    = 1'b0;
        spk_valid_d   = 1'b0;
        gain_d        = gain_q;
        gain_up_d     = gain_up_q;
        div_d         = div_q;
        changed       = (effect_q != prev_effect_q);
        g_cur         = changed ? 4'd15 : gain_q;
        dir_cur       = changed ? 1'b0 : gain_up_q;
        div_cur       = changed ? '0 : div_q;
        xm            = {{7{x_mic_q[8]}}, x_mic_q};
        xs            = {{7{x_spk_q[8]}}, x_spk_q};
        prod          = xm * $signed({12'd0, g_cur});
        vm            = $signed({13'd0, vol_q}) + 16'sd1;
        sp            = (xs * vm) >>> 3;
        y             = xm;
        c             = 8'h00;
`ifdef TEAM_06_DELAY_LINE_EN
        line_d   = line_q;
        wr_ptr_d = wr_ptr_q;
        ptr_cur  = changed ? '0 : wr_ptr_q;
        d16      = changed ? 16'sd0 : {{8{line_q[ptr_cur][7]}}, line_q[ptr_cur]};
        wr_val   = x_mic_q[7:0];
`endif
        case (pipe_q)
            P_IDLE: if (sample_valid) begin
                x_mic_d  = $signed({1'b0, mic_aud}) - 9'sd128;
                x_spk_d  = $signed({1'b0, spk_aud}) - 9'sd128;
                talk_d   = state;
                eff_en_d = eff_en;
                vol_en_d = vol_en;
                mute_d   = mute_tog;
                effect_d = current_effect;
                vol_d    = vol;
                pipe_d   = P_COMP;
            end
            P_COMP: begin
                pipe_d        = P_OUT;
                prev_effect_d = effect_q;
                gain_d        = g_cur;
                gain_up_d     = dir_cur;
                div_d         = div_cur;
`ifdef TEAM_06_DELAY_LINE_EN
                if (changed) begin
                    for (int i = 0; i < DEPTH; i++) line_d[i] = 8'h00;
                    wr_ptr_d = '0;
                end
`endif
                if (talk_q) begin
                    if (eff_en_q) begin
                        case (effect_q)
`ifdef TEAM_06_DELAY_LINE_EN
                            EFF_ECHO:   y = (xm + d16) >>> 1;
                            EFF_REVERB: begin
                                y      = xm + (d16 >>> 1);
                                wr_val = clamp8(y);
                            end
`endif
                            EFF_TREM: begin
                                y = prod >>> 4;
                                // Triangle LFO: a step landing on an end point only flips direction.
                                if (div_cur == DW'(TREM_DIV - 1)) begin
                                    div_d = '0;
                                    if (dir_cur) begin
                                        if (g_cur == 4'd15) gain_up_d = 1'b0;
                                        else                gain_d    = g_cur + 4'd1;
                                    end else begin
                                        if (g_cur == 4'd0)  gain_up_d = 1'b1;
                                        else                gain_d    = g_cur - 4'd1;
                                    end
                                end else begin
                                    div_d = div_cur + DW'(1);
                                end
                            end
                            EFF_SOFT: y = xm >>> 1;
                            default:  y = xm;
                        endcase
                    end
                    c           = clamp8(y);
                    tx_aud_d    = {~c[7], c[6:0]};
                    tx_valid_d  = 1'b1;
                    spk_out_d   = 8'd128;
                    spk_valid_d = 1'b1;
`ifdef TEAM_06_DELAY_LINE_EN
                    line_d[ptr_cur] = wr_val;
                    wr_ptr_d        = ptr_cur + PW'(1);
`endif
                end else begin
                    c           = clamp8(sp);
                    tx_aud_d    = 8'd128;
                    spk_out_d   = (vol_en_q && !mute_q) ? {~c[7], c[6:0]} : 8'd128;
                    spk_valid_d = 1'b1;
                end
            end
            default: pipe_d = P_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q        <= P_IDLE;
            x_mic_q       <= '0;
            x_spk_q       <= '0;
            talk_q        <= 1'b0;
            eff_en_q      <= 1'b0;
            vol_en_q      <= 1'b0;
            mute_q        <= 1'b0;
            effect_q      <= 3'b000;
            vol_q         <= 3'b000;
            prev_effect_q <= 3'b000;
            tx_aud_q      <= 8'd128;
            spk_out_q     <= 8'd128;
            tx_valid_q    <= 1'b0;
            spk_valid_q   <= 1'b0;
            gain_q        <= 4'd15;
            gain_up_q     <= 1'b0;
            div_q         <= '0;
`ifdef TEAM_06_DELAY_LINE_EN
            for (int i = 0; i < DEPTH; i++) line_q[i] <= 8'h00;
            wr_ptr_q <= '0;
`endif
        end else begin
            pipe_q        <= pipe_d;
            x_mic_q       <= x_mic_d;
            x_spk_q       <= x_spk_d;
            talk_q        <= talk_d;
            eff_en_q      <= eff_en_d;
            vol_en_q      <= vol_en_d;
            mute_q        <= mute_d;
            effect_q      <= effect_d;
            vol_q         <= vol_d;
            prev_effect_q <= prev_effect_d;
            tx_aud_q      <= tx_aud_d;
            spk_out_q     <= spk_out_d;
            tx_valid_q    <= tx_valid_d;
            spk_valid_q   <= spk_valid_d;
            gain_q        <= gain_d;
            gain_up_q     <= gain_up_d;
            div_q         <= div_d;
`ifdef TEAM_06_DELAY_LINE_EN
            line_q   <= line_d;
            wr_ptr_q <= wr_ptr_d;
`endif
        end
    end

    assign tx_aud    = tx_aud_q;
    assign tx_valid  = tx_valid_q;
    assign spk_out   = spk_out_q;
    assign spk_valid = spk_valid_q;
endmodule

// File: tb/tb_team_06_audio_path.sv
// tb/tb_team_06_audio_path.sv - directed scoreboard bench for team_06_audio_path
module tb_team_06_audio_path;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic [7:0] mic_aud = 8'd128;
    logic [7:0] spk_aud = 8'd128;
    logic       state = 1'b0;
    logic       eff_en = 1'b0;
    logic       vol_en = 1'b1;
    logic [2:0] current_effect = 3'b000;
    logic       mute_tog = 1'b0;
    logic [2:0] vol = 3'd7;
    logic [7:0] tx_aud;
    logic       tx_valid;
    logic [7:0] spk_out;
    logic       spk_valid;

    typedef struct packed {
        logic       talk;
        logic [7:0] tx;
        logic [7:0] spk;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    team_06_audio_path #(.DEPTH(16), .TREM_DIV(1)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid),
        .mic_aud(mic_aud), .spk_aud(spk_aud), .state(state),
        .eff_en(eff_en), .vol_en(vol_en), .current_effect(current_effect),
        .mute_tog(mute_tog), .vol(vol), .tx_aud(tx_aud), .tx_valid(tx_valid),
        .spk_out(spk_out), .spk_valid(spk_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic observe(input string tag);
        exp_t e;
        if ((tx_valid || spk_valid) && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " tx_valid"}, tx_valid, e.talk);
            chk({tag, " spk_valid"}, spk_valid, 1);
            chk({tag, " tx_aud"}, tx_aud, e.tx);
            chk({tag, " spk_out"}, spk_out, e.spk);
        end else begin
            chk({tag, " strobe"}, {tx_valid, spk_valid}, 2'b11);
        end
    endtask

    // One accepted sample: strobe must be absent at n+1 and present at n+2.
    task automatic do_sample(input logic [7:0] mic, input logic [7:0] spk,
                             input logic [7:0] exp_tx, input logic [7:0] exp_spk,
                             input string tag);
        exp_t e;
        e.talk = state; e.tx = exp_tx; e.spk = exp_spk;
        sb.push_back(e);
        @(negedge clk);
        mic_aud = mic; spk_aud = spk; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk({tag, " early"}, {tx_valid, spk_valid}, 2'b00);
        @(negedge clk);
        observe(tag);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset tx_aud", tx_aud, 128);
        chk("reset spk_out", spk_out, 128);
        chk("reset strobes", {tx_valid, spk_valid}, 2'b00);

        state = 1'b0; vol_en = 1'b1; mute_tog = 1'b0; vol = 3'd7;
        do_sample(8'd50, 8'd200, 8'd128, 8'd200, "list_vol7");
        vol = 3'd3;
        do_sample(8'd50, 8'd200, 8'd128, 8'd164, "list_vol3");
        vol = 3'd0;
        do_sample(8'd50, 8'd200, 8'd128, 8'd137, "list_vol0");
        vol = 3'd7;
        do_sample(8'd50, 8'd0, 8'd128, 8'd0, "list_min");
        mute_tog = 1'b1;
        do_sample(8'd50, 8'd200, 8'd128, 8'd128, "list_mute");
        mute_tog = 1'b0; vol_en = 1'b0;
        do_sample(8'd50, 8'd200, 8'd128, 8'd128, "list_voloff");
        vol_en = 1'b1;

        state = 1'b1; eff_en = 1'b1; current_effect = 3'b100;
        do_sample(8'd0, 8'd200, 8'd64, 8'd128, "soft_min");
        do_sample(8'd255, 8'd200, 8'd191, 8'd128, "soft_max");
        eff_en = 1'b0;
        do_sample(8'd0, 8'd200, 8'd0, 8'd128, "soft_bypass");
        eff_en = 1'b1; current_effect = 3'b111;
        do_sample(8'd37, 8'd200, 8'd37, 8'd128, "undef_effect");

        current_effect = 3'b001;
`ifdef TEAM_06_DELAY_LINE_EN
        do_sample(8'd228, 8'd128, 8'd178, 8'd128, "echo_first");
        for (int i = 0; i < 15; i++) do_sample(8'd128, 8'd128, 8'd128, 8'd128, "echo_gap");
        do_sample(8'd128, 8'd128, 8'd178, 8'd128, "echo_tap");
`else
        do_sample(8'd228, 8'd128, 8'd228, 8'd128, "echo_first");
        for (int i = 0; i < 16; i++) do_sample(8'd128, 8'd128, 8'd128, 8'd128, "echo_gap");
`endif

        current_effect = 3'b011;
        for (int i = 0; i < 40; i++) do_sample(8'd255, 8'd128, 8'd255, 8'd128, "reverb_sat");

        current_effect = 3'b010;
        for (int i = 0; i < 16; i++) do_sample(8'd144, 8'd128, 8'(143 - i), 8'd128, "trem_down");
        do_sample(8'd144, 8'd128, 8'd128, 8'd128, "trem_floor");
        do_sample(8'd144, 8'd128, 8'd129, 8'd128, "trem_up1");
        do_sample(8'd144, 8'd128, 8'd130, 8'd128, "trem_up2");
        current_effect = 3'b000;
        do_sample(8'd144, 8'd128, 8'd144, 8'd128, "normal");
        current_effect = 3'b010;
        do_sample(8'd144, 8'd128, 8'd143, 8'd128, "trem_restart");

        state = 1'b0; vol = 3'd7;
        sb.push_back('{talk: 1'b0, tx: 8'd128, spk: 8'd200});
        @(negedge clk);
        spk_aud = 8'd200; sample_valid = 1'b1;
        @(negedge clk);
        spk_aud = 8'd0;
        @(negedge clk);
        sample_valid = 1'b0;
        observe("drop_first");
        @(negedge clk);
        chk("drop_second strobe", {tx_valid, spk_valid}, 2'b00);
        @(negedge clk);
        chk("drop hold spk_out", spk_out, 200);

        state = 1'b1; current_effect = 3'b100;
        do_sample(8'd0, 8'd128, 8'd64, 8'd128, "pre_reset");
        @(negedge clk);
        mic_aud = 8'd255; sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort strobes", {tx_valid, spk_valid}, 2'b00);
        chk("abort tx_aud", tx_aud, 128);
        chk("abort spk_out", spk_out, 128);
        @(negedge clk);
        chk("abort late strobe", {tx_valid, spk_valid}, 2'b00);
        current_effect = 3'b010;
        do_sample(8'd144, 8'd128, 8'd143, 8'd128, "post_reset_trem");

        chk("scoreboard empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
